// File: rtl/icache_miss_handler.sv
// rtl/icache_miss_handler.sv - instruction cache hit/miss controller
// Updates use bits on hits; on misses picks a clock-style victim, fills the block, and returns the missed word.
module icache_miss_handler #(
  parameter int DATA_WIDTH     = 32,
  parameter int BLOCK_WORDS    = 16,
  parameter int MEM_ADDR_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic                      i_valid,
  input  logic                      i_cache_hit,
  input  logic [3:0]                i_hit_blocks,
  input  logic [7:0]                i_tag_bits,
  input  logic [3:0]                i_set_bits,
  input  logic [3:0]                i_block_offset_bits,
  input  logic [7:0]                i_status_array_data,
  output logic                      o_halt,
  output logic                      o_mem_req_valid,
  input  logic                      i_mem_req_ready,
  output logic [MEM_ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                      i_mem_rdata_valid,
  input  logic [DATA_WIDTH-1:0]     i_mem_rdata,
  output logic                      o_data_we,
  output logic [1:0]                o_data_way,
  output logic [3:0]                o_data_set,
  output logic [3:0]                o_data_word,
  output logic [DATA_WIDTH-1:0]     o_data_wdata,
  output logic                      o_tag_we,
  output logic [1:0]                o_tag_way,
  output logic [3:0]                o_tag_set,
  output logic [7:0]                o_tag_wdata,
  output logic                      o_status_we,
  output logic [3:0]                o_status_set,
  output logic [7:0]                o_status_wdata,
  output logic                      o_resp_valid,
  output logic [DATA_WIDTH-1:0]     o_resp_data
);

  typedef enum logic [2:0] {IDLE, REQ, FILL, UPDATE, RESP} state_t;

  state_t                state_q, state_d;
  logic [7:0]            tag_q, tag_d;
  logic [3:0]            set_q, set_d;
  logic [3:0]            off_q, off_d;
  logic [7:0]            stat_q, stat_d;
  logic [1:0]            victim_q, victim_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] resp_q, resp_d;
  logic                  hit_we_q, hit_we_d;
  logic [3:0]            hit_set_q, hit_set_d;
  logic [7:0]            hit_wdata_q, hit_wdata_d;

  logic [1:0]            hit_idx;
  logic [7:0]            s_eff;

  // Set use[t] (and valid[t] on a fill); once every use bit is set, keep only use[t].
  function automatic logic [7:0] use_update(input logic [7:0] s, input logic [1:0] t,
                                            input logic fill);
    logic [7:0] r;
    r = s;
    r[{t, 1'b1}] = 1'b1;
    if (fill) r[{t, 1'b0}] = 1'b1;
    if (r[1] && r[3] && r[5] && r[7]) r = (r & 8'h55) | (8'h02 << {t, 1'b0});
    return r;
  endfunction

  function automatic logic [1:0] victim_sel(input logic [7:0] s);
    if      (!s[0]) return 2'd0;
    else if (!s[2]) return 2'd1;
    else if (!s[4]) return 2'd2;
    else if (!s[6]) return 2'd3;
    else if (!s[1]) return 2'd0;
    else if (!s[3]) return 2'd1;
    else if (!s[5]) return 2'd2;
    else if (!s[7]) return 2'd3;
    else            return 2'd0;
  endfunction

  always_comb begin
    if      (i_hit_blocks[1]) hit_idx = 2'd1;
    else if (i_hit_blocks[2]) hit_idx = 2'd2;
    else if (i_hit_blocks[3]) hit_idx = 2'd3;
    else                      hit_idx = 2'd0;
  end

  // A hit write landing this cycle on the same set is newer than the array read.
  assign s_eff = (hit_we_q && hit_set_q == i_set_bits) ? hit_wdata_q : i_status_array_data;

  assign o_mem_addr   = MEM_ADDR_WIDTH'({tag_q, set_q, 4'h0});
  assign o_data_way   = victim_q;
  assign o_data_set   = set_q;
  assign o_data_word  = cnt_q;
  assign o_data_wdata = i_mem_rdata;
  assign o_tag_way    = victim_q;
  assign o_tag_set    = set_q;
  assign o_tag_wdata  = tag_q;
  assign o_resp_data  = resp_q;

  always_comb begin
    state_d         = state_q;
    tag_d           = tag_q;
    set_d           = set_q;
    off_d           = off_q;
    stat_d          = stat_q;
    victim_d        = victim_q;
    cnt_d           = cnt_q;
    resp_d          = resp_q;
    hit_we_d        = 1'b0;
    hit_set_d       = hit_set_q;
    hit_wdata_d     = hit_wdata_q;
    o_halt          = 1'b0;
    o_mem_req_valid = 1'b0;
    o_data_we       = 1'b0;
    o_tag_we        = 1'b0;
    o_status_we     = hit_we_q;
    o_status_set    = hit_set_q;
    o_status_wdata  = hit_wdata_q;
    o_resp_valid    = 1'b0;

    case (state_q)
      IDLE: begin
        o_halt = i_valid & ~i_cache_hit;
        if (i_valid && i_cache_hit) begin
          hit_we_d    = 1'b1;
          hit_set_d   = i_set_bits;
          hit_wdata_d = use_update(i_status_array_data, hit_idx, 1'b0);
        end else if (i_valid) begin
          tag_d    = i_tag_bits;
          set_d    = i_set_bits;
          off_d    = i_block_offset_bits;
          stat_d   = s_eff;
          victim_d = victim_sel(s_eff);
          state_d  = REQ;
        end
      end
      REQ: begin
        o_halt          = 1'b1;
        o_mem_req_valid = 1'b1;
        if (i_mem_req_ready) begin
          cnt_d   = 4'd0;
          state_d = FILL;
        end
      end
      FILL: begin
        o_halt = 1'b1;
        if (i_mem_rdata_valid) begin
          o_data_we = 1'b1;
          cnt_d     = cnt_q + 4'd1;
          if (cnt_q == off_q) resp_d = i_mem_rdata;
          if (cnt_q == 4'(BLOCK_WORDS - 1)) state_d = UPDATE;
        end
      end
      UPDATE: begin
        o_halt         = 1'b1;
        o_tag_we       = 1'b1;
        o_status_we    = 1'b1;
        o_status_set   = set_q;
        o_status_wdata = use_update(stat_q, victim_q, 1'b1);
        state_d        = RESP;
      end
      RESP: begin
        o_resp_valid = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      tag_q       <= '0;
      set_q       <= '0;
      off_q       <= '0;
      stat_q      <= '0;
      victim_q    <= '0;
      cnt_q       <= '0;
      resp_q      <= '0;
      hit_we_q    <= 1'b0;
      hit_set_q   <= '0;
      hit_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      set_q       <= set_d;
      off_q       <= off_d;
      stat_q      <= stat_d;
      victim_q    <= victim_d;
      cnt_q       <= cnt_d;
      resp_q      <= resp_d;
      hit_we_q    <= hit_we_d;
      hit_set_q   <= hit_set_d;
      hit_wdata_q <= hit_wdata_d;
    end
  end

endmodule

// File: tb/tb_icache_miss_handler.sv
// tb/tb_icache_miss_handler.sv - directed bench for icache_miss_handler
// Linear directed steps with hand-computed expectations checked by immediate assertions.
module tb_icache_miss_handler;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        i_valid, i_cache_hit;
  logic [3:0]  i_hit_blocks;
  logic [7:0]  i_tag_bits;
  logic [3:0]  i_set_bits, i_block_offset_bits;
  logic [7:0]  i_status_array_data;
  logic        o_halt, o_mem_req_valid, i_mem_req_ready;
  logic [15:0] o_mem_addr;
  logic        i_mem_rdata_valid;
  logic [31:0] i_mem_rdata;
  logic        o_data_we;
  logic [1:0]  o_data_way;
  logic [3:0]  o_data_set, o_data_word;
  logic [31:0] o_data_wdata;
  logic        o_tag_we;
  logic [1:0]  o_tag_way;
  logic [3:0]  o_tag_set;
  logic [7:0]  o_tag_wdata;
  logic        o_status_we;
  logic [3:0]  o_status_set;
  logic [7:0]  o_status_wdata;
  logic        o_resp_valid;
  logic [31:0] o_resp_data;

  int total = 0;
  int bad   = 0;

  icache_miss_handler dut (
    .clk(clk), .arst_n(arst_n),
    .i_valid(i_valid), .i_cache_hit(i_cache_hit), .i_hit_blocks(i_hit_blocks),
    .i_tag_bits(i_tag_bits), .i_set_bits(i_set_bits),
    .i_block_offset_bits(i_block_offset_bits), .i_status_array_data(i_status_array_data),
    .o_halt(o_halt), .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
    .o_mem_addr(o_mem_addr), .i_mem_rdata_valid(i_mem_rdata_valid), .i_mem_rdata(i_mem_rdata),
    .o_data_we(o_data_we), .o_data_way(o_data_way), .o_data_set(o_data_set),
    .o_data_word(o_data_word), .o_data_wdata(o_data_wdata),
    .o_tag_we(o_tag_we), .o_tag_way(o_tag_way), .o_tag_set(o_tag_set), .o_tag_wdata(o_tag_wdata),
    .o_status_we(o_status_we), .o_status_set(o_status_set), .o_status_wdata(o_status_wdata),
    .o_resp_valid(o_resp_valid), .o_resp_data(o_resp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic miss_detect(input logic [7:0] tag, input logic [3:0] set,
                             input logic [3:0] off, input logic [7:0] stat);
    i_valid = 1'b1; i_cache_hit = 1'b0; i_hit_blocks = 4'b0000;
    i_tag_bits = tag; i_set_bits = set; i_block_offset_bits = off;
    i_status_array_data = stat;
    #1;
    chk("miss_halt_same_cycle", 32'(o_halt), 32'd1);
    chk("miss_no_req_yet", 32'(o_mem_req_valid), 32'd0);
  endtask

  task automatic miss_finish(input logic [7:0] tag, input logic [3:0] set,
                             input logic [3:0] off, input logic [1:0] victim,
                             input logic [7:0] exp_stat, input int wait_cycles);
    tick();
    chk("req_valid", 32'(o_mem_req_valid), 32'd1);
    chk("req_addr", 32'(o_mem_addr), 32'({tag, set, 4'h0}));
    for (int w = 0; w < wait_cycles; w++) begin
      i_mem_rdata_valid = 1'b1; i_mem_rdata = 32'hDEAD;
      #1;
      chk("req_hold_valid", 32'(o_mem_req_valid), 32'd1);
      chk("req_hold_addr", 32'(o_mem_addr), 32'({tag, set, 4'h0}));
      chk("req_beat_ignored", 32'(o_data_we), 32'd0);
      tick();
    end
    i_mem_rdata_valid = 1'b0; i_mem_req_ready = 1'b1;
    tick();
    i_mem_req_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 4 || i == 9) begin
        i_mem_rdata_valid = 1'b0;
        #1;
        chk("gap_no_write", 32'(o_data_we), 32'd0);
        tick();
      end
      i_mem_rdata_valid = 1'b1; i_mem_rdata = 32'h100 + 32'(i);
      #1;
      chk("fill_we", 32'(o_data_we), 32'd1);
      chk("fill_way_set_word", 32'({o_data_way, o_data_set, o_data_word}),
          32'({victim, set, 4'(i)}));
      chk("fill_wdata", o_data_wdata, 32'h100 + 32'(i));
      chk("fill_halt", 32'(o_halt), 32'd1);
      tick();
    end
    i_mem_rdata_valid = 1'b0;
    #1;
    chk("upd_tag_we", 32'(o_tag_we), 32'd1);
    chk("upd_tag_way_set", 32'({o_tag_way, o_tag_set}), 32'({victim, set}));
    chk("upd_tag_wdata", 32'(o_tag_wdata), 32'(tag));
    chk("upd_status_we", 32'(o_status_we), 32'd1);
    chk("upd_status_set", 32'(o_status_set), 32'(set));
    chk("upd_status_wdata", 32'(o_status_wdata), 32'(exp_stat));
    chk("upd_halt", 32'(o_halt), 32'd1);
    tick();
    chk("resp_valid", 32'(o_resp_valid), 32'd1);
    chk("resp_data", o_resp_data, 32'h100 + 32'(off));
    chk("resp_halt_low", 32'(o_halt), 32'd0);
    chk("resp_no_writes", 32'({o_tag_we, o_status_we}), 32'd0);
    i_valid = 1'b0;
    tick();
    chk("after_resp_valid_low", 32'(o_resp_valid), 32'd0);
    chk("after_resp_no_req", 32'(o_mem_req_valid), 32'd0);
  endtask

  initial begin
    arst_n = 1'b0;
    i_valid = 1'b0; i_cache_hit = 1'b0; i_hit_blocks = 4'b0000;
    i_tag_bits = 8'h00; i_set_bits = 4'h0; i_block_offset_bits = 4'h0;
    i_status_array_data = 8'h00; i_mem_req_ready = 1'b0;
    i_mem_rdata_valid = 1'b0; i_mem_rdata = 32'h0;
    tick(); tick();
    chk("rst_halt", 32'(o_halt), 32'd0);
    chk("rst_strobes", 32'({o_mem_req_valid, o_data_we, o_tag_we, o_status_we, o_resp_valid}), 32'd0);
    chk("rst_addr", 32'(o_mem_addr), 32'd0);
    chk("rst_resp_data", o_resp_data, 32'd0);
    chk("rst_status_wdata", 32'(o_status_wdata), 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    tick();

    for (int k = 0; k < 6; k++) begin
      i_mem_rdata_valid = 1'($urandom_range(0, 1)); i_mem_rdata = $urandom;
      #1;
      chk("idle_beat_ignored", 32'(o_data_we), 32'd0);
      chk("idle_halt", 32'(o_halt), 32'd0);
      tick();
    end
    i_mem_rdata_valid = 1'b0;

    // Hit on set 5, way 2, status 0x55 -> 0x75 next cycle.
    i_valid = 1'b1; i_cache_hit = 1'b1; i_hit_blocks = 4'b0100;
    i_set_bits = 4'd5; i_status_array_data = 8'h55;
    #1;
    chk("hit_no_halt", 32'(o_halt), 32'd0);
    chk("hit_no_we_same_cycle", 32'(o_status_we), 32'd0);
    tick();
    i_valid = 1'b0; i_cache_hit = 1'b0;
    #1;
    chk("hit_status_we", 32'(o_status_we), 32'd1);
    chk("hit_status_set", 32'(o_status_set), 32'd5);
    chk("hit_status_wdata", 32'(o_status_wdata), 32'h75);
    chk("hit_halt_low", 32'(o_halt), 32'd0);
    tick();
    chk("hit_we_one_pulse", 32'(o_status_we), 32'd0);

    // Miss: invalid way 3 chosen; 3-cycle ready wait.
    miss_detect(8'hA3, 4'd7, 4'd3, 8'h15);
    miss_finish(8'hA3, 4'd7, 4'd3, 2'd3, 8'hD5, 3);

    // Miss, all valid, way 1 first with use=0; top offset.
    miss_detect(8'h12, 4'd1, 4'd15, 8'hF7);
    miss_finish(8'h12, 4'd1, 4'd15, 2'd1, 8'h5D, 0);

    // Miss, all valid and used: fall back to way 0; offset 0.
    miss_detect(8'hFE, 4'd15, 4'd0, 8'hFF);
    miss_finish(8'hFE, 4'd15, 4'd0, 2'd0, 8'h57, 1);

    // Hit on set 2 way 0 then immediate miss on set 2: forwarded 0x57 picks way 1.
    i_valid = 1'b1; i_cache_hit = 1'b1; i_hit_blocks = 4'b0001;
    i_set_bits = 4'd2; i_status_array_data = 8'h55;
    tick();
    miss_detect(8'h22, 4'd2, 4'd5, 8'h55);
    chk("fwd_hit_we", 32'(o_status_we), 32'd1);
    chk("fwd_hit_wdata", 32'(o_status_wdata), 32'h57);
    miss_finish(8'h22, 4'd2, 4'd5, 2'd1, 8'h5F, 0);

    // Reset after 6 fill beats abandons the miss.
    miss_detect(8'h44, 4'd9, 4'd2, 8'h00);
    tick();
    i_mem_req_ready = 1'b1;
    tick();
    i_mem_req_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      i_mem_rdata_valid = 1'b1; i_mem_rdata = 32'h200 + 32'(i);
      tick();
    end
    i_mem_rdata_valid = 1'b0; i_valid = 1'b0;
    arst_n = 1'b0;
    #1;
    chk("mid_rst_halt", 32'(o_halt), 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("mid_rst_no_tag_status", 32'({o_tag_we, o_status_we}), 32'd0);
      tick();
    end
    @(negedge clk);
    arst_n = 1'b1;
    tick();
    i_mem_rdata_valid = 1'b1;
    #1;
    chk("post_rst_halt", 32'(o_halt), 32'd0);
    chk("post_rst_no_fill", 32'(o_data_we), 32'd0);
    chk("post_rst_no_writes", 32'({o_tag_we, o_status_we, o_resp_valid}), 32'd0);
    i_mem_rdata_valid = 1'b0;
    miss_detect(8'h5A, 4'd3, 4'd1, 8'h00);
    tick();
    chk("post_rst_idle_req", 32'(o_mem_req_valid), 32'd1);
    chk("post_rst_idle_addr", 32'(o_mem_addr), 32'h5A30);
    i_valid = 1'b0;
    arst_n = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
